ace_ccu_snoop_sequencer: RTL

// Sequences coherent transactions from NoReq requesters (master-group snoop FSMs) onto a single

---
 rtl/ace_ccu_snoop_sequencer_pkg.sv | 18 +
 rtl/ace_ccu_snoop_sequencer_line_table.sv | 70 +++++++
 rtl/ace_ccu_snoop_sequencer.sv | 119 +++++++++++
 3 files changed

// File: rtl/ace_ccu_snoop_sequencer_pkg.sv
// Shared widths and helpers for the CCU snoop sequencer and its line table.
package ace_ccu_snoop_sequencer_pkg;

    localparam int unsigned DefNoReq       = 4;
    localparam int unsigned DefAddrWidth   = 64;
    localparam int unsigned DefLineBytes   = 64;
    localparam int unsigned DefMaxInflight = 4;
    localparam int unsigned DefReqInfoW    = 8;
    localparam int unsigned DefOffW        = $clog2(DefLineBytes);
    localparam int unsigned DefTagW        = (DefMaxInflight > 1) ? $clog2(DefMaxInflight) : 1;

    typedef logic [DefTagW-1:0] seq_tag_t;

    function automatic logic [DefAddrWidth-DefOffW-1:0] line_key(input logic [DefAddrWidth-1:0] addr);
        return addr[DefAddrWidth-1:DefOffW];
    endfunction

endpackage

// File: rtl/ace_ccu_snoop_sequencer_line_table.sv
// In-flight line table: per-requester hit lookup, lowest-free allocation, free by tag.
module ace_ccu_snoop_sequencer_line_table
    import ace_ccu_snoop_sequencer_pkg::*;
#(
    parameter int unsigned NoReq       = DefNoReq,
    parameter int unsigned KeyW        = DefAddrWidth - DefOffW,
    parameter int unsigned MaxInflight = DefMaxInflight,
    parameter int unsigned TagW        = DefTagW
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NoReq-1:0][KeyW-1:0] lookup_key_i,
    output logic [NoReq-1:0]           hit_o,
    input  logic                       alloc_i,
    input  logic [KeyW-1:0]            alloc_key_i,
    output logic [TagW-1:0]            alloc_tag_o,
    output logic                       full_o,
    input  logic                       free_i,
    input  logic [TagW-1:0]            free_tag_i,
    output logic                       err_o,
    output logic                       any_valid_o
);

    logic [MaxInflight-1:0]           valid_q;
    logic [MaxInflight-1:0][KeyW-1:0] key_q;
    logic                             found;

    // Lookups and allocation only see the registered table, so a freed slot is
    // reusable from the following cycle.
    always_comb begin
        hit_o = '0;
        for (int i = 0; i < NoReq; i++) begin
            for (int s = 0; s < MaxInflight; s++) begin
                if (valid_q[s] && (key_q[s] == lookup_key_i[i])) hit_o[i] = 1'b1;
            end
        end
    end

    always_comb begin
        alloc_tag_o = '0;
        found       = 1'b0;
        for (int s = 0; s < MaxInflight; s++) begin
            if (!found && !valid_q[s]) begin
                alloc_tag_o = TagW'(s);
                found       = 1'b1;
            end
        end
    end

    assign full_o      = &valid_q;
    assign any_valid_o = |valid_q;

    // A valid free and an allocation never target the same slot: allocation
    // only picks a slot that is currently invalid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            key_q   <= '0;
            err_o   <= 1'b0;
        end else begin
            err_o <= free_i & ~valid_q[free_tag_i];
            if (free_i && valid_q[free_tag_i]) valid_q[free_tag_i] <= 1'b0;
            if (alloc_i) begin
                valid_q[alloc_tag_o] <= 1'b1;
                key_q[alloc_tag_o]   <= alloc_key_i;
            end
        end
    end

endmodule

// File: rtl/ace_ccu_snoop_sequencer.sv
// Round-robin sequencer of coherent requests onto one snoop path, serialising same-line traffic.
module ace_ccu_snoop_sequencer
    import ace_ccu_snoop_sequencer_pkg::*;
#(
    parameter int unsigned NoReq       = DefNoReq,
    parameter int unsigned AddrWidth   = DefAddrWidth,
    parameter int unsigned LineBytes   = DefLineBytes,
    parameter int unsigned MaxInflight = DefMaxInflight,
    parameter int unsigned ReqInfoW    = DefReqInfoW,
    localparam int unsigned SrcW       = (NoReq > 1) ? $clog2(NoReq) : 1,
    localparam int unsigned TagW       = (MaxInflight > 1) ? $clog2(MaxInflight) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NoReq-1:0]            req_valid_i,
    output logic [NoReq-1:0]            req_ready_o,
    input  logic [NoReq*AddrWidth-1:0]  req_addr_i,
    input  logic [NoReq*ReqInfoW-1:0]   req_info_i,
    output logic                        gnt_valid_o,
    input  logic                        gnt_ready_i,
    output logic [AddrWidth-1:0]        gnt_addr_o,
    output logic [ReqInfoW-1:0]         gnt_info_o,
    output logic [SrcW-1:0]             gnt_src_o,
    output logic [TagW-1:0]             gnt_tag_o,
    input  logic                        done_valid_i,
    input  logic [TagW-1:0]             done_tag_i,
    output logic                        busy_o,
    output logic                        err_o
);

    localparam int unsigned OffW = $clog2(LineBytes);
    localparam int unsigned KeyW = AddrWidth - OffW;

    logic [NoReq-1:0][KeyW-1:0]  key;
    logic [NoReq-1:0][AddrWidth-1:0] addr;
    logic [NoReq-1:0][ReqInfoW-1:0]  info;
    logic [NoReq-1:0]            hit;
    logic [NoReq-1:0]            eligible;
    logic                        full;
    logic                        any_valid;
    logic [TagW-1:0]             alloc_tag;
    logic                        out_free;
    logic                        win;
    logic [SrcW-1:0]             win_idx;
    logic [SrcW-1:0]             rr_ptr_q;

    always_comb begin
        for (int i = 0; i < NoReq; i++) begin
            addr[i] = req_addr_i[i*AddrWidth +: AddrWidth];
            info[i] = req_info_i[i*ReqInfoW +: ReqInfoW];
            key[i]  = addr[i][AddrWidth-1:OffW];
        end
    end

    ace_ccu_snoop_sequencer_line_table #(
        .NoReq       (NoReq),
        .KeyW        (KeyW),
        .MaxInflight (MaxInflight),
        .TagW        (TagW)
    ) i_line_table (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .lookup_key_i (key),
        .hit_o        (hit),
        .alloc_i      (win),
        .alloc_key_i  (key[win_idx]),
        .alloc_tag_o  (alloc_tag),
        .full_o       (full),
        .free_i       (done_valid_i),
        .free_tag_i   (done_tag_i),
        .err_o        (err_o),
        .any_valid_o  (any_valid)
    );

    // Gating with rst_ni keeps req_ready_o low while reset is held.
    assign out_free = ~gnt_valid_o | gnt_ready_i;
    assign eligible = req_valid_i & ~hit & {NoReq{~full & out_free & rst_ni}};

    always_comb begin
        win     = 1'b0;
        win_idx = '0;
        for (int k = 0; k < NoReq; k++) begin
            if (!win && eligible[(int'(rr_ptr_q) + k) % NoReq]) begin
                win     = 1'b1;
                win_idx = SrcW'((int'(rr_ptr_q) + k) % NoReq);
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        for (int i = 0; i < NoReq; i++) begin
            req_ready_o[i] = win && (win_idx == SrcW'(i));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gnt_valid_o <= 1'b0;
            gnt_addr_o  <= '0;
            gnt_info_o  <= '0;
            gnt_src_o   <= '0;
            gnt_tag_o   <= '0;
            rr_ptr_q    <= '0;
        end else if (win) begin
            gnt_valid_o <= 1'b1;
            gnt_addr_o  <= addr[win_idx];
            gnt_info_o  <= info[win_idx];
            gnt_src_o   <= win_idx;
            gnt_tag_o   <= alloc_tag;
            rr_ptr_q    <= (int'(win_idx) == NoReq - 1) ? '0 : win_idx + 1'b1;
        end else if (gnt_ready_i) begin
            gnt_valid_o <= 1'b0;
        end
    end

    assign busy_o = any_valid | gnt_valid_o;

endmodule
